// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared framing states and sample-to-duty helpers
// Purpose: types and pure functions shared by the I2S frame sequencer.
// Contents: state_t (UNLOCKED/SYNC/RUN), mid_duty(), to_offset_duty().
package i2s_pkg;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_SYNC     = 2'd1,
      ST_RUN      = 2'd2
   } state_t;

   // Mid-scale duty (50 %) for a pwm_w-bit channel.
   function automatic int unsigned mid_duty(input int unsigned pwm_w);
      return 32'd1 << (pwm_w - 1);
   endfunction

   // Keep the top pwm_w bits of a sample_w-bit two's complement word and
   // flip its MSB, giving offset binary (most negative -> 0, zero -> mid).
   function automatic logic [31:0] to_offset_duty(input logic [31:0] word,
                                                  input int unsigned sample_w,
                                                  input int unsigned pwm_w);
      logic [31:0] upper;
      upper = word >> (sample_w - pwm_w);
      upper = upper ^ (32'd1 << (pwm_w - 1));
      return upper & ((32'd1 << pwm_w) - 32'd1);
   endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// rtl/i2s_sync_edge.sv - two-flop synchroniser with registered rise detect
// Purpose: bring one asynchronous pin into the clk domain.
// Ports: clk, rst_n (async, active-low), din (raw pin),
//        level (synchronised level), rise (one-cycle pulse, pin edge + 3 clk).
module i2s_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise
);

   logic s_meta;
   logic s_sync;
   logic s_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_meta <= 1'b0;
         s_sync <= 1'b0;
         s_last <= 1'b0;
         rise   <= 1'b0;
      end else begin
         s_meta <= din;
         s_sync <= s_meta;
         s_last <= s_sync;
         rise   <= s_sync & ~s_last;
      end
   end

   assign level = s_sync;

endmodule

// File: rtl/i2s_frame_sequencer.sv
// rtl/i2s_frame_sequencer.sv - I2S framing, duty conversion and period-aligned release
// Purpose: frame a raw I2S stream into stereo samples and hand duty pairs to
//          the PWM channels only at PWM period boundaries.
// Ports: clk, rst_n (async, active-low); bit_clk_in, lr_clk_in, sdin_in (raw I2S);
//        pwm_period_end (period wrap pulse); left_duty, right_duty, duty_valid
//        (release pulse); locked, frame_err (pulse), overrun (sticky).
module i2s_frame_sequencer #(
   parameter int SAMPLE_W = 16,
   parameter int PWM_W    = 8,
   parameter int TIMEOUT  = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_clk_in,
   input  logic             lr_clk_in,
   input  logic             sdin_in,
   input  logic             pwm_period_end,
   output logic [PWM_W-1:0] left_duty,
   output logic [PWM_W-1:0] right_duty,
   output logic             duty_valid,
   output logic             locked,
   output logic             frame_err,
   output logic             overrun
);

   import i2s_pkg::*;

   localparam int NW = $clog2(SAMPLE_W + 2);
   localparam logic [NW-1:0] N_MAX  = NW'(SAMPLE_W + 1);
   localparam logic [NW-1:0] N_FULL = NW'(SAMPLE_W);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [WW-1:0] WD_TOP  = WW'(TIMEOUT);
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
   localparam logic [PWM_W-1:0] MID = PWM_W'(mid_duty(PWM_W));

   logic bclk_rise;
   logic lr_s;
   logic sd_s;
   logic bclk_level_unused;
   logic lr_rise_unused;
   logic sd_rise_unused;

   i2s_sync_edge u_sync_bclk (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (bit_clk_in),
      .level (bclk_level_unused),
      .rise  (bclk_rise)
   );

   i2s_sync_edge u_sync_lr (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (lr_clk_in),
      .level (lr_s),
      .rise  (lr_rise_unused)
   );

   i2s_sync_edge u_sync_sd (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (sdin_in),
      .level (sd_s),
      .rise  (sd_rise_unused)
   );

   state_t              state;
   logic                prev_valid;   // lr_prev holds a real sample
   logic                lr_prev;
   logic [NW-1:0]       n;
   logic [SAMPLE_W-1:0] shreg;
   logic [PWM_W-1:0]    left_hold;    // left half of the frame being built
   logic [PWM_W-1:0]    pend_l;
   logic [PWM_W-1:0]    pend_r;
   logic                have_left;
   logic                one_frame;    // first complete frame seen in SYNC
   logic                pend_rdy;
   logic                mid_done;     // MID already released while unlocked
   logic [WW-1:0]       wd_cnt;

   logic [NW-1:0]       n_inc;
   logic [SAMPLE_W-1:0] word_next;
   logic [PWM_W-1:0]    duty_new;
   logic                trans;
   logic                full;
   logic                wd_fire;
   logic                release_now;

   always_comb begin
      n_inc       = (n == N_MAX) ? n : n + NW'(1);
      word_next   = (n_inc <= N_FULL) ? {shreg[SAMPLE_W-2:0], sd_s} : shreg;
      trans       = bclk_rise && prev_valid && (lr_s != lr_prev);
      full        = (n_inc >= N_FULL);
      duty_new    = PWM_W'(to_offset_duty(32'(word_next), SAMPLE_W, PWM_W));
      wd_fire     = !bclk_rise && (wd_cnt == WD_LAST);
      release_now = pwm_period_end && locked && pend_rdy;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_UNLOCKED;
         prev_valid <= 1'b0;
         lr_prev    <= 1'b0;
         n          <= '0;
         shreg      <= '0;
         left_hold  <= MID;
         pend_l     <= MID;
         pend_r     <= MID;
         have_left  <= 1'b0;
         one_frame  <= 1'b0;
         pend_rdy   <= 1'b0;
         mid_done   <= 1'b0;
         wd_cnt     <= '0;
         left_duty  <= MID;
         right_duty <= MID;
         duty_valid <= 1'b0;
         locked     <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         duty_valid <= 1'b0;
         frame_err  <= 1'b0;

         if (bclk_rise) begin
            wd_cnt <= '0;
         end else if (wd_cnt != WD_TOP) begin
            wd_cnt <= wd_cnt + WW'(1);
         end

         // Release reads the pending pair as registered, so a frame committed
         // in the same cycle is not seen until the next period end.
         if (pwm_period_end) begin
            if (!locked) begin
               if (!mid_done) begin
                  left_duty  <= MID;
                  right_duty <= MID;
                  duty_valid <= 1'b1;
                  mid_done   <= 1'b1;
               end
            end else if (pend_rdy) begin
               left_duty  <= pend_l;
               right_duty <= pend_r;
               duty_valid <= 1'b1;
               pend_rdy   <= 1'b0;
            end
         end
         if (locked) begin
            mid_done <= 1'b0;
         end

         if (bclk_rise) begin
            prev_valid <= 1'b1;
            lr_prev    <= lr_s;
            shreg      <= word_next;
            n          <= trans ? '0 : n_inc;
         end

         if (trans) begin
            if (state == ST_UNLOCKED) begin
               state     <= ST_SYNC;
               have_left <= 1'b0;
               one_frame <= 1'b0;
            end else if (!full) begin
               frame_err <= 1'b1;
               state     <= ST_UNLOCKED;
               locked    <= 1'b0;
               pend_rdy  <= 1'b0;
            end else if (!lr_prev) begin
               left_hold <= duty_new;
               have_left <= 1'b1;
            end else begin
               // Right word closes the frame only if its left word was seen.
               have_left <= 1'b0;
               if (have_left) begin
                  if (state == ST_RUN) begin
                     pend_l   <= left_hold;
                     pend_r   <= duty_new;
                     pend_rdy <= 1'b1;
                     if (pend_rdy && !release_now) begin
                        overrun <= 1'b1;
                     end
                  end else if (one_frame) begin
                     state  <= ST_RUN;
                     locked <= 1'b1;
                  end else begin
                     one_frame <= 1'b1;
                  end
               end
            end
         end else if (wd_fire) begin
            state    <= ST_UNLOCKED;
            locked   <= 1'b0;
            pend_rdy <= 1'b0;
         end
      end
   end

endmodule

// File: doc/i2s_frame_sequencer.md
Name: i2s_frame_sequencer

Overview:
Sequencing front end between the raw I2S pins and the stereo PWM outputs. It synchronises bit_clk, lr_clk and sdin into the system clock domain and frames the serial stream into left and right samples. It converts each sample to an unsigned duty word and double-buffers the pair. New duties are released to both PWM channels only at a PWM period boundary, so a channel never sees a mid-period duty change. It also tracks lock, framing errors and overrun.

Parameters:
SAMPLE_W, 16, bits captured per channel word (MSB first)
PWM_W, 8, duty width; must be ≤ SAMPLE_W
TIMEOUT, 255, clk cycles without a bit_clk rising edge before lock is dropped

Ports:
clk  in  1  system clock; must run ≥ 8× bit_clk
rst_n  in  1  reset, asynchronous, active-low
bit_clk_in  in  1  raw I2S bit clock (asynchronous)
lr_clk_in  in  1  raw I2S word select; 0 = left, 1 = right
sdin_in  in  1  raw I2S serial data
pwm_period_end  in  1  one-cycle pulse from the PWM block at its period wrap
left_duty  out  PWM_W  duty for the left PWM channel
right_duty  out  PWM_W  duty for the right PWM channel
duty_valid  out  1  one-cycle pulse when left_duty and right_duty load
locked  out  1  stream is framed correctly
frame_err  out  1  one-cycle pulse on a framing fault
overrun  out  1  sticky: a frame was overwritten before release

Behaviour:
- Reset, asynchronous and active-low, applies the following values:
  - left_duty = right_duty = MID, where MID = 2^(PWM_W-1), i.e. 0x80.
  - duty_valid = 0, frame_err = 0, locked = 0, overrun = 0.
  - FSM = UNLOCKED.
  - Pending buffer empty; bit counter = 0.
- Synchronisation:
  - 2-flop synchroniser on each of the three inputs.
  - Rising-edge detect on synchronised bit_clk gives the internal pulse bclk_rise.
  - Pin edge to bclk_rise takes 3 clk.
  - All framing logic acts only on cycles where bclk_rise = 1.
- At each bclk_rise, sample d = sdin_s and l = lr_s. Let lr_prev be l from the previous bclk_rise. A transition is l ≠ lr_prev.
- Bit counter n counts edges since the last transition and saturates at SAMPLE_W+1. On each edge, n increments, then d is shifted into the shift register if the new n ≤ SAMPLE_W. The transition edge itself counts and shifts (I2S one-bit delay: that bit is the LSB of the outgoing word). n then resets to 0 after a transition edge.
- FSM states:
  - UNLOCKED: wait for the first transition, then go to SYNC. No word is captured.
  - SYNC: at each transition, if n ≥ SAMPLE_W, capture the word; otherwise raise frame_err and return to UNLOCKED. After 2 consecutive complete frames (each a left word followed by a right word), set locked = 1 and go to RUN.
  - RUN: same capture rule. A short word raises frame_err, clears locked and sends the FSM to UNLOCKED.
  - Watchdog: TIMEOUT clk cycles with no bclk_rise, in any state, sends the FSM to UNLOCKED and clears locked. frame_err does not pulse.
- Capture and conversion:
  - The word completed at a transition belongs to channel lr_prev.
  - duty = the upper PWM_W bits of the word with the MSB inverted (two's complement to offset binary). Examples: 0x7FFF → 0xFF, 0x8000 → 0x00, 0x0000 → 0x80.
  - A left word goes to pend_l. A right word goes to pend_r and sets pend_rdy; a right capture completes the frame.
  - In UNLOCKED and SYNC, captures do not set pend_rdy.
- Release:
  - On pwm_period_end with pend_rdy = 1, load left_duty/right_duty from the pending values, pulse duty_valid and clear pend_rdy.
  - On pwm_period_end with locked = 0, load MID into both outputs and pulse duty_valid, then suppress further releases until lock returns.
  - Outputs change only on the cycle after pwm_period_end.
- Simultaneous events:
  - Frame completion and pwm_period_end in the same cycle: the release uses the pending values as they were before this cycle. The new frame becomes pending with pend_rdy = 1, and overrun is not set.
  - Frame completion while pend_rdy = 1 and no release this cycle: the pending values are overwritten and overrun is set. overrun is cleared only by reset.
- Reset mid-word discards the partial word; outputs return to MID immediately.

Decomposition:
- Shared package i2s_pkg holds:
  - State enum {UNLOCKED, SYNC, RUN}.
  - The MID constant function of PWM_W.
  - The to_offset_duty conversion function.
- One sub-module: i2s_sync_edge (2-flop synchroniser plus registered rise detect, outputs sync level and rise pulse). It is instantiated for bit_clk; lr_clk and sdin use its level output only.

Test Plan:
- Reset with bit_clk toggling → left_duty = right_duty = 0x80, locked = 0, no duty_valid until the first pwm_period_end, which loads 0x80.
- Three frames L = 0x7FFF, R = 0x8000 (SAMPLE_W = 16), then pwm_period_end → locked = 1 after frame 2; after the pulse, left_duty = 0xFF, right_duty = 0x00, duty_valid high for one cycle.
- Locked stream, then a 12-bit left word → frame_err pulse, locked = 0; next pwm_period_end loads 0x80/0x80.
- Frames A (0x4000/0xC000) then B (0x0000/0x0000) with no period end between, then pwm_period_end → overrun = 1, outputs 0x80/0x80 (frame B).
- Frame-end and pwm_period_end in the same cycle → outputs take the prior pending pair, new pair stays pending, overrun = 0; the next period end loads the new pair.
- Stop bit_clk for 256 clk while locked → locked = 0, no frame_err; assert rst_n low mid-word → all outputs at reset values asynchronously.
